// File: rtl/titan_lsu_if.sv
// ---------------------------------------------------------------------------
// titan_lsu_if
//   Data-side Wishbone B4 classic bus between titan_lsu (master) and the
//   memory/peripheral fabric (slave).
//
//   Signals (direction seen from the master):
//     wbm_addr_o  out 32  word-aligned byte address
//     wbm_dat_o   out 32  write data, replicated across byte lanes
//     wbm_sel_o   out 4   byte lane select
//     wbm_we_o    out 1   write enable
//     wbm_cyc_o   out 1   bus cycle in progress
//     wbm_stb_o   out 1   strobe
//     wbm_dat_i   in  32  read data
//     wbm_ack_i   in  1   slave acknowledge
//     wbm_err_i   in  1   slave error
//
//   Handshake: a transfer is offered while wbm_cyc_o & wbm_stb_o are high and
//   completes in the first cycle the slave raises wbm_ack_i or wbm_err_i; the
//   master holds address/data/select stable until then.
// ---------------------------------------------------------------------------
interface titan_lsu_if;
    logic [31:0] wbm_addr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_addr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_addr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/titan_lsu.sv
// ---------------------------------------------------------------------------
// titan_lsu
//   Load/store unit between the MEM pipeline stage and the data-side
//   Wishbone bus. One classic Wishbone cycle per aligned request; misaligned
//   requests complete immediately without touching the bus.
//
//   Ports:
//     clk_i, rst_i          clock (rising edge), synchronous active-low reset
//     lsu_addr_i[31:0]      byte address
//     lsu_wdata_i[31:0]     store data (value in low bits)
//     lsu_mread_i/mwrite_i  level-held load / store request (store wins)
//     lsu_mword_i/mhw_i/mbyte_i  access size flags
//     lsu_munsigned_i       zero-extend loads
//     lsu_data_o[31:0]      load result, valid with lsu_ack_o, held until
//                           the next completion
//     lsu_cyc_o             access in progress (MEM stalls while high and
//                           lsu_ack_o is low)
//     lsu_ack_o             one-cycle completion pulse
//     lsu_err_o             bus error or timeout, qualifies lsu_ack_o
//     wb                    Wishbone master modport
//     dbg_state[1:0]        current FSM state (IDLE=0, BUS=1, DONE=2)
//
//   MEM-side handshake: MEM holds its request level; the unit raises
//   lsu_cyc_o in the same cycle and pulses lsu_ack_o once when the access is
//   finished. A request still present in the cycle after the pulse is a new
//   access.
// ---------------------------------------------------------------------------
module titan_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_mread_i,
    input  logic        lsu_mwrite_i,
    input  logic        lsu_mword_i,
    input  logic        lsu_mhw_i,
    input  logic        lsu_mbyte_i,
    input  logic        lsu_munsigned_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_cyc_o,
    output logic        lsu_ack_o,
    output logic        lsu_err_o,
    titan_lsu_if.master wb,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;

    logic        req;
    logic        is_word;
    logic        is_half;
    logic        is_byte;
    logic        misaligned;
    logic [3:0]  sel_c;
    logic [31:0] wdat_c;

    // Attributes of the access in flight, needed to align the read data.
    logic [1:0]  lat_off;
    logic        lat_half;
    logic        lat_byte;
    logic        lat_unsigned;

    logic [7:0]  tmo_cnt;
    logic        tmo_hit;
    logic [31:0] rd_shift;
    logic [31:0] rdata_ext;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign req = lsu_mread_i | lsu_mwrite_i;

    // Word flag has priority; with no size flag at all the access is a word.
    assign is_half = !lsu_mword_i && lsu_mhw_i;
    assign is_byte = !lsu_mword_i && !lsu_mhw_i && lsu_mbyte_i;
    assign is_word = !is_half && !is_byte;

    assign misaligned = (is_word && (lsu_addr_i[1:0] != 2'b00)) ||
                        (is_half && lsu_addr_i[0]);

    always_comb begin
        sel_c  = 4'b1111;
        wdat_c = lsu_wdata_i;
        if (is_byte) begin
            sel_c  = 4'b0001 << lsu_addr_i[1:0];
            wdat_c = {4{lsu_wdata_i[7:0]}};
        end else if (is_half) begin
            sel_c  = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            wdat_c = {2{lsu_wdata_i[15:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Read data alignment and extension
    // ------------------------------------------------------------------
    assign rd_shift = wb.wbm_dat_i >> {lat_off, 3'b000};

    always_comb begin
        rdata_ext = rd_shift;
        if (lat_byte) begin
            rdata_ext = {{24{!lat_unsigned && rd_shift[7]}}, rd_shift[7:0]};
        end else if (lat_half) begin
            rdata_ext = {{16{!lat_unsigned && rd_shift[15]}}, rd_shift[15:0]};
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = misaligned ? DONE : BUS;
                end
            end
            BUS: begin
                if (wb.wbm_err_i || wb.wbm_ack_i || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational so MEM already stalls in the request cycle.
    assign lsu_cyc_o = ((state == IDLE) && req) || (state == BUS) || (state == DONE);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wb.wbm_cyc_o  <= 1'b0;
            wb.wbm_stb_o  <= 1'b0;
            wb.wbm_we_o   <= 1'b0;
            wb.wbm_sel_o  <= 4'b0000;
            wb.wbm_addr_o <= 32'd0;
            wb.wbm_dat_o  <= 32'd0;
            lsu_ack_o     <= 1'b0;
            lsu_err_o     <= 1'b0;
            lsu_data_o    <= 32'd0;
            tmo_cnt       <= 8'd0;
            lat_off       <= 2'b00;
            lat_half      <= 1'b0;
            lat_byte      <= 1'b0;
            lat_unsigned  <= 1'b0;
        end else begin
            // Completion status lives for the DONE cycle only.
            lsu_ack_o <= 1'b0;
            lsu_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            // MEM raises its own exception; report a clean completion.
                            lsu_ack_o  <= 1'b1;
                            lsu_data_o <= 32'd0;
                        end else begin
                            wb.wbm_cyc_o  <= 1'b1;
                            wb.wbm_stb_o  <= 1'b1;
                            wb.wbm_we_o   <= lsu_mwrite_i;
                            wb.wbm_sel_o  <= sel_c;
                            wb.wbm_addr_o <= {lsu_addr_i[31:2], 2'b00};
                            wb.wbm_dat_o  <= wdat_c;
                            lat_off       <= lsu_addr_i[1:0];
                            lat_half      <= is_half;
                            lat_byte      <= is_byte;
                            lat_unsigned  <= lsu_munsigned_i;
                            tmo_cnt       <= 8'd0;
                        end
                    end
                end
                BUS: begin
                    if (wb.wbm_err_i || wb.wbm_ack_i || tmo_hit) begin
                        wb.wbm_cyc_o <= 1'b0;
                        wb.wbm_stb_o <= 1'b0;
                        tmo_cnt      <= 8'd0;
                        lsu_ack_o    <= 1'b1;
                        // Error beats a simultaneous ack; timeout is an error too.
                        if (wb.wbm_err_i || !wb.wbm_ack_i) begin
                            lsu_err_o  <= 1'b1;
                            lsu_data_o <= 32'd0;
                        end else begin
                            lsu_data_o <= rdata_ext;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
